// File: rtl/softmax_pkg.sv
// Shared constants and types for the softmax divide datapath.
// Holds the widths used by both this feeder and the 40/32 divider wrapper,
// the feeder state enum, and the packed dividend/divisor payload.
package softmax_pkg;

   localparam int unsigned IN_W    = 24;
   localparam int unsigned FRAC_SH = 16;
   localparam int unsigned A_W     = IN_W + FRAC_SH;
   localparam int unsigned B_W     = 32;
   localparam int unsigned DEPTH   = 64;
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // One divider request: dividend, divisor and end-of-frame marker.
   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic           last;
   } div_pair_t;

endpackage

// File: rtl/softmax_exp_buf.sv
// Frame buffer for exponential values.
// Single-port DEPTH x IN_W array with a registered read port. A write takes
// priority over a read on the shared address. The array and the read
// register are not reset; the owner tracks which entries are valid.
// Ports: clk, we (write enable), re (read enable), addr, wdata, rdata.
module softmax_exp_buf
   import softmax_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [PTR_W-1:0] addr,
   input  logic [IN_W-1:0]  wdata,
   output logic [IN_W-1:0]  rdata
);

   logic [IN_W-1:0] mem [DEPTH];

   // Single shared port: write or registered read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/softmax_div_feeder.sv
// Softmax divider feeder.
// Buffers one frame of unsigned exp values while summing them, then replays
// each value as {exp_i, FRAC_SH zeros} with the frame sum as divisor on a
// valid/ready output, one pair per cycle when downstream is always ready.
// Ports: clk, rst (async active-high); s_valid/s_ready/s_data/s_last input
// stream; m_valid/m_ready/m_a/m_b/m_last output pairs; ovf sticky flag for
// a frame longer than DEPTH.
// Optional build macro SOFTMAX_FEED_STATS_EN adds frame_cnt (wrapping count
// of completed frames) and drop_cnt (saturating count of dropped beats).
module softmax_div_feeder
   import softmax_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [IN_W-1:0] s_data,
   input  logic            s_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [A_W-1:0]  m_a,
   output logic [B_W-1:0]  m_b,
   output logic            m_last,
   output logic            ovf
`ifdef SOFTMAX_FEED_STATS_EN
   ,
   output logic [15:0]     frame_cnt,
   output logic [15:0]     drop_cnt
`endif
);

   // Elaboration guards: sum must hold DEPTH full-scale values, DEPTH pow2.
   if (B_W < IN_W + $clog2(DEPTH)) begin : g_bw_chk
      $error("softmax_div_feeder: B_W too narrow for IN_W and DEPTH");
   end
   if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("softmax_div_feeder: DEPTH must be a power of two");
   end

   state_e          state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] rd_ptr;
   logic [B_W-1:0]   sum;
   logic             s1_valid;   // buffer read register holds a pending entry
   logic             s1_last;    // that pending entry is the frame's last
   div_pair_t        pair_q;
   logic [IN_W-1:0]  rd_data;

   logic             hs_in;
   logic             drop;
   logic             wr_en;
   logic             load_out;
   logic             rd_en;
   logic             done_hs;
   logic [PTR_W-1:0] buf_addr;

   assign hs_in    = s_valid && s_ready;
   assign drop     = hs_in && (count == CNT_W'(DEPTH));
   assign wr_en    = hs_in && !drop;
   // Output register refills whenever it is empty or being consumed.
   assign load_out = s1_valid && (!m_valid || m_ready);
   // Prefetch the next entry whenever the read register frees up.
   assign rd_en    = (state != ACCUM) && (rd_ptr < count) && (!s1_valid || load_out);
   assign done_hs  = m_valid && m_ready && m_last;
   assign buf_addr = wr_en ? count[PTR_W-1:0] : rd_ptr[PTR_W-1:0];

   assign m_a    = pair_q.a;
   assign m_b    = pair_q.b;
   assign m_last = pair_q.last;

   softmax_exp_buf u_buf (
      .clk   (clk),
      .we    (wr_en),
      .re    (rd_en),
      .addr  (buf_addr),
      .wdata (s_data),
      .rdata (rd_data)
   );

   // Frame FSM: accumulate, one-cycle load of entry 0, then drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ACCUM;
         s_ready  <= 1'b1;
         m_valid  <= 1'b0;
         pair_q   <= '0;
         ovf      <= 1'b0;
         count    <= '0;
         sum      <= '0;
         rd_ptr   <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (hs_in) begin
                  if (drop) begin
                     ovf <= 1'b1;
                  end else begin
                     // First beat of a new frame clears the previous overflow.
                     if (count == '0) begin
                        ovf <= 1'b0;
                     end
                     count <= count + CNT_W'(1);
                     sum   <= sum + B_W'(s_data);
                  end
                  if (s_last) begin
                     state   <= LOAD;
                     s_ready <= 1'b0;
                     rd_ptr  <= '0;
                  end
               end
            end

            LOAD, DRAIN: begin
               if (state == LOAD) begin
                  state <= DRAIN;
               end

               if (rd_en) begin
                  rd_ptr   <= rd_ptr + CNT_W'(1);
                  s1_valid <= 1'b1;
                  s1_last  <= (rd_ptr == count - CNT_W'(1));
               end else if (load_out) begin
                  s1_valid <= 1'b0;
               end

               if (load_out) begin
                  m_valid     <= 1'b1;
                  pair_q.a    <= {rd_data, FRAC_SH'(0)};
                  pair_q.b    <= sum;
                  pair_q.last <= s1_last;
               end else if (m_valid && m_ready) begin
                  m_valid <= 1'b0;
               end

               if (done_hs) begin
                  state       <= ACCUM;
                  s_ready     <= 1'b1;
                  m_valid     <= 1'b0;
                  pair_q.last <= 1'b0;
                  count       <= '0;
                  sum         <= '0;
                  rd_ptr      <= '0;
                  s1_valid    <= 1'b0;
               end
            end

            default: begin
               state   <= ACCUM;
               s_ready <= 1'b1;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef SOFTMAX_FEED_STATS_EN
   // Completed-frame counter (wraps) and dropped-beat counter (saturates).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (done_hs) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_softmax_div_feeder.sv
// Self-checking bench for softmax_div_feeder: directed frames from the test
// plan plus randomized frames and backpressure, checked against a queue
// model of frame -> (exp_i << FRAC_SH, sum of kept beats, last flag).
module tb_softmax_div_feeder;
   import softmax_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid;
   logic            s_ready;
   logic [IN_W-1:0] s_data;
   logic            s_last;
   logic            m_valid;
   logic            m_ready;
   logic [A_W-1:0]  m_a;
   logic [B_W-1:0]  m_b;
   logic            m_last;
   logic            ovf;
`ifdef SOFTMAX_FEED_STATS_EN
   logic [15:0]     frame_cnt;
   logic [15:0]     drop_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int model_frames = 0;
   int model_drops  = 0;
   logic [IN_W-1:0] frame_q[$];

   always #5 clk = ~clk;

   softmax_div_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_a       (m_a),
      .m_b       (m_b),
      .m_last    (m_last),
      .ovf       (ovf)
`ifdef SOFTMAX_FEED_STATS_EN
      ,
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Push frame_q into the DUT with random idle gaps on s_valid.
   task automatic send_frame();
      int   i = 0;
      int   n = frame_q.size();
      int   guard = 0;
      logic rdy;
      while (i < n && guard < 5000) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = frame_q[i];
         s_last  = (i == n - 1);
         rdy     = s_ready;
         @(posedge clk); #1;
         guard++;
         if (s_valid && rdy) begin
            if (i == 0) chk("ovf_clr", 64'(ovf), 64'(0));
            if (i >= int'(DEPTH) && model_drops < 16'hFFFF) model_drops++;
            i++;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (i < n) chk("send_timeout", 64'(i), 64'(n));
      chk("ovf", 64'(ovf), 64'(n > int'(DEPTH)));
   endtask

   // Consume output pairs; mode 0: always ready, 1: random, 2: 1,0,0 pattern.
   // stop_after >= 0 returns right after that many pairs were accepted.
   task automatic drain(input int mode, input int stop_after);
      int             n_exp;
      longint         sum = 0;
      int             idx = 0;
      int             k = 0;
      int             pat = 0;
      logic           seen = 1'b0;
      logic           prev_stall = 1'b0;
      logic [A_W-1:0] pa = '0;
      logic [B_W-1:0] pb = '0;
      logic           pl = 1'b0;
      n_exp = (frame_q.size() > int'(DEPTH)) ? int'(DEPTH) : frame_q.size();
      for (int j = 0; j < n_exp; j++) sum += longint'(frame_q[j]);
      while (idx < n_exp && k < 2000) begin
         if (m_valid) begin
            if (!seen) begin
               chk("latency", 64'(k), 64'(2));
               seen = 1'b1;
            end
            chk("s_ready_drain", 64'(s_ready), 64'(0));
            if (prev_stall) begin
               chk("hold_a", 64'(m_a), 64'(pa));
               chk("hold_b", 64'(m_b), 64'(pb));
               chk("hold_last", 64'(m_last), 64'(pl));
            end
         end
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = ((pat % 3) == 0);
         endcase
         pat++;
         if (m_valid && m_ready) begin
            chk("m_a", 64'(m_a), 64'(frame_q[idx]) << FRAC_SH);
            chk("m_b", 64'(m_b), 64'(sum));
            chk("m_last", 64'(m_last), 64'(idx == n_exp - 1));
            idx++;
         end
         prev_stall = m_valid && !m_ready;
         pa = m_a;
         pb = m_b;
         pl = m_last;
         @(posedge clk); #1;
         k++;
         if (idx == stop_after) begin
            m_ready = 1'b0;
            return;
         end
      end
      m_ready = 1'b0;
      if (idx < n_exp) begin
         chk("drain_timeout", 64'(idx), 64'(n_exp));
      end else begin
         chk("m_valid_end", 64'(m_valid), 64'(0));
         chk("s_ready_end", 64'(s_ready), 64'(1));
         model_frames++;
      end
`ifdef SOFTMAX_FEED_STATS_EN
      chk("frame_cnt", 64'(frame_cnt), 64'(model_frames & 16'hFFFF));
      chk("drop_cnt", 64'(drop_cnt), 64'(model_drops));
`endif
   endtask

   task automatic run_frame(input int mode);
      send_frame();
      drain(mode, -1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 64'(s_ready), 64'(1));
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_a", 64'(m_a), 64'(0));
      chk("rst_m_b", 64'(m_b), 64'(0));
      chk("rst_m_last", 64'(m_last), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Basic frame, then the same frame under a 1,0,0 ready pattern.
      frame_q = '{24'h000100, 24'h000200, 24'h000300, 24'h000400};
      run_frame(0);
      run_frame(2);

      // Overflow frame: 66 full-scale beats, then a frame clearing ovf.
      frame_q.delete();
      for (int i = 0; i < 66; i++) frame_q.push_back(24'hFFFFFF);
      run_frame(1);

      // Single-beat frame.
      frame_q = '{24'h000005};
      run_frame(0);

      // All-zero frame: divisor forwarded as zero.
      frame_q = '{24'h0, 24'h0, 24'h0};
      run_frame(1);

      // Reset in the middle of draining.
      frame_q = '{24'h000010, 24'h000020, 24'h000030, 24'h000040};
      send_frame();
      drain(0, 2);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
      chk("mid_rst_s_ready", 64'(s_ready), 64'(1));
      chk("mid_rst_m_b", 64'(m_b), 64'(0));
      chk("mid_rst_ovf", 64'(ovf), 64'(0));
      model_frames = 0;
      model_drops  = 0;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("post_rst_idle", 64'(m_valid), 64'(0));
      end
      frame_q = '{24'h000010, 24'h000010};
      run_frame(0);

      // Randomized frames, including lengths past DEPTH.
      for (int f = 0; f < 10; f++) begin
         int n;
         n = int'($urandom_range(1, 70));
         frame_q.delete();
         for (int i = 0; i < n; i++) frame_q.push_back(IN_W'($urandom));
         run_frame(int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
